// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Slot index width; a single-digit display still gets a 1-bit index.
  function automatic int idx_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

  // True when the scanner parameters describe a buildable configuration.
  function automatic bit params_legal(input int n_digits, input int tick_div,
                                      input int blank_cycles);
    return (n_digits >= 1) && (n_digits <= 16) && (tick_div >= 2) &&
           (blank_cycles >= 0) && (blank_cycles < tick_div);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle: packed digit/mask inputs and the anode/segment drive.
// Latency: n/a (wiring only).
// Backpressure: none; the scanner free-runs and never stalls its source.
interface seven_seg_scanner_if #(
  parameter int N_DIGITS = 8
);
  import seven_seg_pkg::*;

  localparam int IDX_W = idx_width(N_DIGITS);

  logic                  enable;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp_mask;
  logic [N_DIGITS-1:0]   blank_mask;
  logic [N_DIGITS-1:0]   an;
  logic [6:0]            seg;
  logic                  dp;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_start;

  // Score/control logic side.
  modport master (
    output enable, digits, dp_mask, blank_mask,
    input  an, seg, dp, digit_idx, frame_start
  );

  // Scanner side.
  modport slave (
    input  enable, digits, dp_mask, blank_mask,
    output an, seg, dp, digit_idx, frame_start
  );

endinterface

// File: rtl/seven_seg_hex_decode.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Full 16-entry lookup; the default only keeps the block latch-free.
  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode scanner with per-slot blanking dead-time.
// Latency: outputs registered, one cycle behind the slot/tick counters.
// Backpressure: none; inputs are shadowed and sampled only at frame boundaries.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic               clk,
  input logic               reset,
  seven_seg_scanner_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = idx_width(N_DIGITS);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  if (!params_legal(N_DIGITS, TICK_DIV, BLANK_CYCLES)) begin : g_bad_params
    $error("seven_seg_scanner: illegal N_DIGITS/TICK_DIV/BLANK_CYCLES");
  end

  logic [CNT_W-1:0]      tick_cnt;
  logic [IDX_W-1:0]      slot_idx;
  logic [4*N_DIGITS-1:0] digits_sh;
  logic [N_DIGITS-1:0]   dp_sh;
  logic [N_DIGITS-1:0]   blank_sh;

  logic [N_DIGITS-1:0]   an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  frame_start_q;

  logic                  tick_wrap;
  logic                  frame_end;
  logic                  in_blank;
  logic                  drive;
  logic [3:0]            sel_digit;
  logic                  sel_dp;
  logic                  sel_blank;
  logic [N_DIGITS-1:0]   an_drive;
  logic [6:0]            seg_dec;

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign frame_end = tick_wrap && (slot_idx == IDX_LAST);

  // With no dead-time the compare would be constant, so it is elided.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    assign in_blank = (tick_cnt < BLANK_LIM);
  end

  // Select the shadowed digit, dp and blank bit for the current slot.
  always_comb begin
    sel_digit = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    an_drive  = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (slot_idx == IDX_W'(k)) begin
        sel_digit   = digits_sh[4*k +: 4];
        sel_dp      = dp_sh[k];
        sel_blank   = blank_sh[k];
        an_drive[k] = 1'b0;
      end
    end
  end

  seven_seg_hex_decode u_decode (
    .hex (sel_digit),
    .seg (seg_dec)
  );

  assign drive = !in_blank && bus.enable && !sel_blank;

  // Refresh prescaler and slot counter; both restart at slot 0, count 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      slot_idx <= '0;
    end else if (tick_wrap) begin
      tick_cnt <= '0;
      slot_idx <= (slot_idx == IDX_LAST) ? '0 : slot_idx + IDX_W'(1);
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Shadow inputs only at frame boundaries so a frame never shows mixed data.
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      digits_sh <= bus.digits;
      dp_sh     <= bus.dp_mask;
      blank_sh  <= bus.blank_mask;
    end
  end

  // Register pin drive from the current counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      idx_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= drive ? an_drive : '1;
      seg_q         <= drive ? seg_dec : SEG_OFF;
      dp_q          <= drive ? ~sel_dp : 1'b1;
      idx_q         <= slot_idx;
      frame_start_q <= (tick_cnt == '0) && (slot_idx == '0);
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed checks of the scanner in three configurations.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  seven_seg_scanner_if #(.N_DIGITS(4)) bus_a ();
  seven_seg_scanner_if #(.N_DIGITS(2)) bus_b ();
  seven_seg_scanner_if #(.N_DIGITS(1)) bus_c ();

  seven_seg_scanner #(.N_DIGITS(4), .TICK_DIV(8), .BLANK_CYCLES(2)) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  seven_seg_scanner #(.N_DIGITS(2), .TICK_DIV(3), .BLANK_CYCLES(0)) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );
  seven_seg_scanner #(.N_DIGITS(1), .TICK_DIV(4), .BLANK_CYCLES(0)) dut_c (
    .clk (clk), .reset (reset), .bus (bus_c)
  );

  typedef struct {
    int          edge_n;
    logic        rst;
    logic        en;
    logic [15:0] dig;
    logic [3:0]  dpm;
    logic [3:0]  bm;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  idx;
    logic        fs;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;
  int e = 0;

  function automatic vec_t mk(input int edge_n, input logic rst, input logic en,
                              input logic [15:0] dig, input logic [3:0] dpm,
                              input logic [3:0] bm, input logic [3:0] an,
                              input logic [6:0] seg, input logic dp,
                              input logic [1:0] idx, input logic fs);
    vec_t v;
    v.edge_n = edge_n; v.rst = rst; v.en = en; v.dig = dig; v.dpm = dpm; v.bm = bm;
    v.an = an; v.seg = seg; v.dp = dp; v.idx = idx; v.fs = fs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset            = v.rst;
    bus_a.enable     = v.en;
    bus_a.digits     = v.dig;
    bus_a.dp_mask    = v.dpm;
    bus_a.blank_mask = v.bm;
    bus_b.enable     = v.en;
    bus_c.enable     = v.en;
  endtask

  initial begin
    int a_low[4];
    int a_runs[4];
    int b_low[2];
    int a_fs_bad, a_multi, b_fs_bad, b_alloff, c_an_bad, c_idx_bad, c_fs_bad, c_seg_bad;
    logic [3:0] a_prev;

    // Frame 0: digits 3210, dp on digit 1, digit 2 blanked.
    vecs.push_back(mk(  1, 0, 1, 16'h3210, 4'b0010, 4'b0100, 4'hF, 7'h7F, 1, 0, 1));
    vecs.push_back(mk(  2, 0, 1, 16'h3210, 4'b0010, 4'b0100, 4'hF, 7'h7F, 1, 0, 0));
    vecs.push_back(mk(  3, 0, 1, 16'h3210, 4'b0010, 4'b0100, 4'hE, 7'h40, 1, 0, 0));
    vecs.push_back(mk(  8, 0, 1, 16'h3210, 4'b0010, 4'b0100, 4'hE, 7'h40, 1, 0, 0));
    vecs.push_back(mk(  9, 0, 1, 16'h3210, 4'b0010, 4'b0100, 4'hF, 7'h7F, 1, 1, 0));
    vecs.push_back(mk( 11, 0, 1, 16'h3210, 4'b0010, 4'b0100, 4'hD, 7'h79, 0, 1, 0));
    // Inputs change in slot 1; frame 0 must keep the old shadow.
    vecs.push_back(mk( 12, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hD, 7'h79, 0, 1, 0));
    vecs.push_back(mk( 19, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1, 2, 0));
    vecs.push_back(mk( 24, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1, 2, 0));
    vecs.push_back(mk( 27, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'h7, 7'h30, 1, 3, 0));
    vecs.push_back(mk( 32, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'h7, 7'h30, 1, 3, 0));
    // Frame 1: digits 8F5A, dp on digit 0, enable dropped for 5 cycles.
    vecs.push_back(mk( 33, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1, 0, 1));
    vecs.push_back(mk( 35, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hE, 7'h08, 0, 0, 0));
    vecs.push_back(mk( 43, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hD, 7'h12, 1, 1, 0));
    vecs.push_back(mk( 44, 0, 0, 16'h8F5A, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1, 1, 0));
    vecs.push_back(mk( 48, 0, 0, 16'h8F5A, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1, 1, 0));
    vecs.push_back(mk( 49, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hF, 7'h7F, 1, 2, 0));
    vecs.push_back(mk( 51, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'hB, 7'h0E, 1, 2, 0));
    vecs.push_back(mk( 59, 0, 1, 16'h8F5A, 4'b0001, 4'b0000, 4'h7, 7'h00, 1, 3, 0));
    vecs.push_back(mk( 60, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'h7, 7'h00, 1, 3, 0));
    vecs.push_back(mk( 64, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'h7, 7'h00, 1, 3, 0));
    // Frame 2: digits EDCB.
    vecs.push_back(mk( 65, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'hF, 7'h7F, 1, 0, 1));
    vecs.push_back(mk( 67, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'hE, 7'h03, 1, 0, 0));
    vecs.push_back(mk( 75, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'hD, 7'h46, 1, 1, 0));
    vecs.push_back(mk( 83, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'hB, 7'h21, 1, 2, 0));
    vecs.push_back(mk( 91, 0, 1, 16'hEDCB, 4'b0000, 4'b0000, 4'h7, 7'h06, 1, 3, 0));
    vecs.push_back(mk( 92, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'h7, 7'h06, 1, 3, 0));
    // Frame 3: digits 9764.
    vecs.push_back(mk( 97, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'hF, 7'h7F, 1, 0, 1));
    vecs.push_back(mk( 99, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'hE, 7'h19, 1, 0, 0));
    vecs.push_back(mk(107, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'hD, 7'h02, 1, 1, 0));
    vecs.push_back(mk(115, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'hB, 7'h78, 1, 2, 0));
    vecs.push_back(mk(123, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'h7, 7'h10, 1, 3, 0));
    // Frame 4: reset pulsed while slot 2, count 5 is shown.
    vecs.push_back(mk(150, 0, 1, 16'h9764, 4'b0000, 4'b0000, 4'hB, 7'h78, 1, 2, 0));
    vecs.push_back(mk(151, 1, 1, 16'h1111, 4'b0000, 4'b0000, 4'hF, 7'h7F, 1, 0, 0));
    vecs.push_back(mk(152, 0, 1, 16'h1111, 4'b0000, 4'b0000, 4'hF, 7'h7F, 1, 0, 1));
    vecs.push_back(mk(154, 0, 1, 16'h1111, 4'b0000, 4'b0000, 4'hE, 7'h79, 1, 0, 0));

    // Initial reset with frame-0 inputs so the shadow loads during reset.
    reset = 1'b1;
    apply(vecs[0]);
    reset = 1'b1;
    bus_b.digits = 8'h21; bus_b.dp_mask = 2'b00; bus_b.blank_mask = 2'b00;
    bus_c.digits = 4'h7;  bus_c.dp_mask = 1'b0;  bus_c.blank_mask = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_an",  32'(bus_a.an), 32'hF);
    chk("reset_seg", 32'(bus_a.seg), 32'h7F);
    chk("reset_dp",  32'(bus_a.dp), 32'h1);
    chk("reset_idx", 32'(bus_a.digit_idx), 32'h0);
    chk("reset_fs",  32'(bus_a.frame_start), 32'h0);
    reset = 1'b0;
    e = 0;

    foreach (vecs[i]) begin
      while (e < vecs[i].edge_n - 1) begin
        @(posedge clk); e++; @(negedge clk);
      end
      apply(vecs[i]);
      @(posedge clk); e++; @(negedge clk);
      chk($sformatf("an@%0d", e),  32'(bus_a.an), 32'(vecs[i].an));
      chk($sformatf("seg@%0d", e), 32'(bus_a.seg), 32'(vecs[i].seg));
      chk($sformatf("dp@%0d", e),  32'(bus_a.dp), 32'(vecs[i].dp));
      chk($sformatf("idx@%0d", e), 32'(bus_a.digit_idx), 32'(vecs[i].idx));
      chk($sformatf("fs@%0d", e),  32'(bus_a.frame_start), 32'(vecs[i].fs));
    end

    // Fresh scan: anode duty, frame period, zero dead-time and single digit.
    reset = 1'b1;
    bus_a.digits = 16'h3210; bus_a.dp_mask = 4'b0000; bus_a.blank_mask = 4'b0000;
    bus_a.enable = 1'b1; bus_b.enable = 1'b1; bus_c.enable = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    a_fs_bad = 0; a_multi = 0; b_fs_bad = 0; b_alloff = 0;
    c_an_bad = 0; c_idx_bad = 0; c_fs_bad = 0; c_seg_bad = 0;
    a_prev = 4'hF;
    for (int k = 0; k < 4; k++) begin a_low[k] = 0; a_runs[k] = 0; end
    for (int k = 0; k < 2; k++) b_low[k] = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); @(negedge clk);
      if (bus_a.frame_start !== ((n - 1) % 32 == 0)) a_fs_bad++;
      if ($countones(~bus_a.an) > 1) a_multi++;
      if (n <= 32) begin
        for (int k = 0; k < 4; k++) begin
          if (bus_a.an[k] == 1'b0) a_low[k]++;
          if (a_prev[k] == 1'b1 && bus_a.an[k] == 1'b0) a_runs[k]++;
        end
      end
      a_prev = bus_a.an;
      if (bus_b.frame_start !== ((n - 1) % 6 == 0)) b_fs_bad++;
      if (bus_b.an == 2'b11) b_alloff++;
      if (n <= 6) begin
        for (int k = 0; k < 2; k++) if (bus_b.an[k] == 1'b0) b_low[k]++;
      end
      if (n == 1) chk("b_seg_d0", 32'(bus_b.seg), 32'h79);
      if (n == 3) chk("b_an_last_d0", 32'(bus_b.an), 32'h2);
      if (n == 4) begin
        chk("b_an_first_d1", 32'(bus_b.an), 32'h1);
        chk("b_seg_d1", 32'(bus_b.seg), 32'h24);
      end
      if (bus_c.an !== 1'b0) c_an_bad++;
      if (bus_c.digit_idx !== 1'b0) c_idx_bad++;
      if (bus_c.frame_start !== ((n - 1) % 4 == 0)) c_fs_bad++;
      if (bus_c.seg !== 7'h78) c_seg_bad++;
    end
    chk("a_fs_period", 32'(a_fs_bad), 32'd0);
    chk("a_multi_low", 32'(a_multi), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("a_low_cycles%0d", k), 32'(a_low[k]), 32'd6);
      chk($sformatf("a_low_runs%0d", k), 32'(a_runs[k]), 32'd1);
    end
    chk("b_fs_period", 32'(b_fs_bad), 32'd0);
    chk("b_alloff", 32'(b_alloff), 32'd0);
    chk("b_low0", 32'(b_low[0]), 32'd3);
    chk("b_low1", 32'(b_low[1]), 32'd3);
    chk("c_an_low", 32'(c_an_bad), 32'd0);
    chk("c_idx", 32'(c_idx_bad), 32'd0);
    chk("c_fs_period", 32'(c_fs_bad), 32'd0);
    chk("c_seg", 32'(c_seg_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised multi-digit seven-segment display scanner that time-multiplexes N_DIGITS common-anode digits from a packed hex input. It owns the refresh prescaler, the digit counter, per-digit anode drive with a blanking dead-time against ghosting, per-digit decimal-point and blank masks, and hex-to-segment decoding. It sits between score/over logic and the board pins, replacing the fixed 8-anode decoder and its external 3-bit counter.

## Interface
- N_DIGITS, 8: digits scanned; legal 1..16.
- TICK_DIV, 100000: clock cycles per digit slot; legal ≥ 2.
- BLANK_CYCLES, 1000: cycles at slot start with all anodes off; legal 0..TICK_DIV-1.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = drive display; 0 = all anodes off, counters keep running.
- digits  in  4*N_DIGITS  hex value per digit; digit k is bits [4k+3:4k].
- dp_mask  in  N_DIGITS  bit k = 1 lights decimal point on digit k.
- blank_mask  in  N_DIGITS  bit k = 1 keeps digit k dark for its whole slot.
- an  out  N_DIGITS  anodes, active low, at most one low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.
- digit_idx  out  $clog2(N_DIGITS) (min 1)  slot currently being scanned.
- frame_start  out  1  one-cycle pulse at start of slot 0.

## Operation
- tick_cnt counts 0..TICK_DIV-1 and wraps; on wrap, digit_idx increments, and wraps from N_DIGITS-1 to 0.
- Slot phase: tick_cnt < BLANK_CYCLES → BLANK; otherwise DRIVE.
- BLANK: an all 1, seg 7'h7F, dp 1.
- DRIVE: an bit digit_idx = 0, others 1; seg = decode(shadow digit); dp = ~shadow dp_mask bit. If enable = 0 or shadow blank_mask bit = 1, output as in BLANK.
- Shadow registers hold digits, dp_mask and blank_mask. They load from the inputs on every reset cycle and on the cycle tick_cnt wraps while digit_idx = N_DIGITS-1. Input changes therefore take effect only at frame boundaries, with no tearing inside a frame.
- enable is not shadowed; it acts on the next output cycle.
- Decode covers all 16 hex values 0-9, A, b, C, d, E, F with standard patterns, e.g. 0 → 7'h40, 8 → 7'h00, F → 7'h0E.
- With N_DIGITS = 1, digit_idx stays 0 and frame_start pulses once per TICK_DIV cycles.

## Timing
- Reset values: an all 1, seg 7'h7F, dp 1, digit_idx 0, frame_start 0, tick_cnt 0.
- All outputs are registered and reflect the counter state of the previous cycle. Edge 1 after reset deassert is slot 0, count 0.
- frame_start is 1 exactly on the edge where count 0 of slot 0 is presented, including edge 1 after reset.
- digit_idx changes on the same edge as the first BLANK cycle of the new slot.
- Anode k is low for exactly TICK_DIV-BLANK_CYCLES consecutive cycles per frame. Frame period is N_DIGITS*TICK_DIV cycles.
- Reset asserted mid-slot: outputs return to reset values on the next edge, and the scan restarts at slot 0, count 0.
- BLANK_CYCLES = 0: no dead-time; anodes switch directly from k to k+1 on one edge.

## Structure
- Package seven_seg_pkg holds the segment-pattern constants for 0-F, SEG_OFF = 7'h7F, and a parameter-legality check helper.
- Sub-module seven_seg_hex_decode is a combinational 4-bit to 7-bit active-low decoder, instantiated once on the mux output.
- Counter width is $clog2(TICK_DIV). Width-elaboration assertions reject illegal parameters.

## Test plan
- N_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2, digits=16'h3210, enable=1 → each slot shows 2 cycles of an=4'hF, then 6 cycles of an=1110/1101/1011/0111 with seg 0/1/2/3 patterns; frame_start every 32 cycles.
- dp_mask=4'b0010, blank_mask=4'b0100 → dp=0 only while an=1101; slot 2 stays fully dark while anodes 0, 1 and 3 still scan.
- digits changed mid-frame at slot 1 → outputs unchanged until the next frame_start; new values appear from slot 0 of the next frame.
- enable dropped for 5 cycles mid-DRIVE → an=4'hF for those cycles; digit_idx and frame_start timing unchanged.
- Reset pulsed at slot 2, count 5 → next edge gives reset values; edge 1 after release has frame_start=1 and digit_idx=0.
- BLANK_CYCLES=0 and N_DIGITS=1 configurations → no all-off cycles; single anode held low continuously; frame_start every TICK_DIV cycles.
